hilo_mdu_ctrl: RTL



---
 rtl/hilo_mdu_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO owner with a radix-2 multiply/divide sequencer: 34-cycle ops, 2-cycle divide-by-zero, pipeline stalled until commit.
// Define MDU_FAST_MUL_EN for a single-cycle multiplier (MULT/MULTU finish like divide-by-zero); divide is always iterative.
module hilo_mdu_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic [1:0]  req_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        cancel,
   input  logic [1:0]  write_hilo,
   input  logic [31:0] hilo_wdata,
   output logic        stall,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] work_q, work_d;
   logic [31:0] opb_q, opb_d;
   logic        div_q, div_d;
   logic        neg_q, neg_d;
   logic        rem_neg_q, rem_neg_d;
   logic        dz_q, dz_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        done_q, done_d;

   logic        accept;
   logic        op_signed;
   logic        b_zero;
   logic [31:0] a_abs, b_abs;
   logic [32:0] rem_sh, diff, sum;
   logic [63:0] div_next, mul_next, prod_fix;
   logic [31:0] quo_fix, rem_fix;

   assign accept    = req_valid & ~cancel & (state_q == S_IDLE);
   assign op_signed = ~req_op[0];
   assign b_zero    = (src_b == '0);
   assign a_abs     = (op_signed & src_a[31]) ? (32'd0 - src_a) : src_a;
   assign b_abs     = (op_signed & src_b[31]) ? (32'd0 - src_b) : src_b;

   // Restoring divide step: bit 32 of the 33-bit difference is the borrow.
   assign rem_sh   = work_q[63:31];
   assign diff     = rem_sh - {1'b0, opb_q};
   assign div_next = diff[32] ? {rem_sh[31:0], work_q[30:0], 1'b0}
                              : {diff[31:0],   work_q[30:0], 1'b1};

   // Shift-add step: the carry out of the accumulator shifts into bit 63.
   assign sum      = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opb_q} : 33'd0);
   assign mul_next = {sum, work_q[31:1]};

   assign prod_fix = neg_q ? (64'd0 - work_q) : work_q;
   assign quo_fix  = neg_q ? (32'd0 - work_q[31:0]) : work_q[31:0];
   assign rem_fix  = rem_neg_q ? (32'd0 - work_q[63:32]) : work_q[63:32];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      work_d    = work_q;
      opb_d     = opb_q;
      div_d     = div_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      dz_d      = dz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (write_hilo[1]) hi_d = hilo_wdata;
            if (write_hilo[0]) lo_d = hilo_wdata;
            if (accept) begin
               div_d     = req_op[1];
               neg_d     = op_signed & (src_a[31] ^ src_b[31]);
               rem_neg_d = op_signed & src_a[31];
               dz_d      = req_op[1] & b_zero;
               cnt_d     = 5'd31;
               if (req_op[1]) begin
                  work_d  = {32'd0, a_abs};
                  opb_d   = b_abs;
                  state_d = b_zero ? S_FIX : S_RUN;
               end else begin
`ifdef MDU_FAST_MUL_EN
                  work_d  = {32'd0, a_abs} * {32'd0, b_abs};
                  opb_d   = a_abs;
                  state_d = S_FIX;
`else
                  work_d  = {32'd0, b_abs};
                  opb_d   = a_abs;
                  state_d = S_RUN;
`endif
               end
            end
         end
         S_RUN: begin
            if (cancel) begin
               state_d = S_IDLE;
            end else begin
               work_d = div_q ? div_next : mul_next;
               if (cnt_q == 5'd0) state_d = S_FIX;
               else               cnt_d   = cnt_q - 5'd1;
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            if (!cancel) begin
               done_d = 1'b1;
               if (!dz_q) begin
                  if (div_q) begin
                     lo_d = quo_fix;
                     hi_d = rem_fix;
                  end else begin
                     hi_d = prod_fix[63:32];
                     lo_d = prod_fix[31:0];
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= 5'd0;
         work_q    <= 64'd0;
         opb_q     <= 32'd0;
         div_q     <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         dz_q      <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         work_q    <= work_d;
         opb_q     <= opb_d;
         div_q     <= div_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         dz_q      <= dz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign busy   = (state_q != S_IDLE);
   assign stall  = busy | accept;
   assign done   = done_q;
   assign hi_out = hi_q;
   assign lo_out = lo_q;

endmodule
